mem_arbiter: RTL

Shares the single 16-bit SRAM port of the DE2 IO controller between the ACE core's instruction-fetch port (read-only) and data port (read/write). Each 32-bit word request is split into two sequential halfword transactions on the IO controller's one-shot request / one-cycle ack interface. Requesters see a hold-until-ack handshake. Arbitration is round-robin, and an ack watchdog keeps a stalled transaction from hanging the core.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_rr.sv | 35 +++
 rtl/mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM port arbiter.
package mem_arb_pkg;

  // Transaction sequencer states: one REQ/WAIT pair per 16-bit half.
  typedef enum logic [2:0] {
    IDLE,
    LO_REQ,
    LO_WAIT,
    HI_REQ,
    HI_WAIT,
    DONE
  } state_t;

  // Grant encodings (also used for the last-served pointer).
  localparam logic GNT_INSTR = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  // Halfword select, appended as the SRAM address LSB.
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  // Width of the ack watchdog counter: enough to hold the timeout, never below 4 bits.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-input round-robin picker; remembers which port was served last.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_instr,
  input  logic req_data,
  input  logic update,
  input  logic served,
  output logic pick
);

  logic last_reg;

  // Last-served pointer; starts at data so the instruction port wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg <= GNT_DATA;
    end else if (update) begin
      last_reg <= served;
    end
  end

  // Pick a lone requester, or on a tie the port that was not served last.
  always_comb begin
    pick = GNT_INSTR;
    if (req_instr && req_data) begin
      pick = (last_reg == GNT_DATA) ? GNT_INSTR : GNT_DATA;
    end else if (req_data) begin
      pick = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction and data ports onto the single 16-bit SRAM
// request/ack interface, splitting each 32-bit word into two halfword
// transactions, with an ack watchdog that aborts stalled transactions.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WADDR_W     = 19,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  // Instruction port
  input  logic               i_req,
  input  logic [WADDR_W-1:0] i_addr,
  output logic               i_ack,
  output logic [31:0]        i_rdata,
  output logic               i_err,
  // Data port
  input  logic               d_req,
  input  logic               d_we,
  input  logic [WADDR_W-1:0] d_addr,
  input  logic [31:0]        d_wdata,
  output logic               d_ack,
  output logic [31:0]        d_rdata,
  output logic               d_err,
  // IO controller
  output logic               mem_read,
  output logic               mem_write,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_write_data,
  input  logic               mem_ack,
  input  logic [31:0]        mem_read_data,
  // Status
  output logic               busy,
  output logic               grant
);

  localparam int CNT_W = cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t               state_reg, state_next;
  logic                 grant_reg, grant_next;
  logic [WADDR_W-1:0]   addr_reg, addr_next;
  logic                 we_reg, we_next;
  logic [31:0]          wdata_reg, wdata_next;
  logic [31:0]          result_reg, result_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 err_reg, err_next;
  logic                 rr_pick;
  logic                 half;
  logic                 in_xfer;
  logic                 unused_rdata_hi;

  // The IO controller only returns data on the low 16 bits.
  assign unused_rdata_hi = ^mem_read_data[31:16];

  mem_arb_rr u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_instr (i_req),
    .req_data  (d_req),
    .update    (state_reg == DONE),
    .served    (grant_reg),
    .pick      (rr_pick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Latched request, assembled result, watchdog counter and abort flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_reg  <= GNT_INSTR;
      addr_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      grant_reg  <= grant_next;
      addr_reg   <= addr_next;
      we_reg     <= we_next;
      wdata_reg  <= wdata_next;
      result_reg <= result_next;
      cnt_reg    <= cnt_next;
      err_reg    <= err_next;
    end
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    addr_next      = addr_reg;
    we_next        = we_reg;
    wdata_next     = wdata_reg;
    result_next    = result_reg;
    cnt_next       = cnt_reg;
    err_next       = err_reg;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    i_ack          = 1'b0;
    i_rdata        = '0;
    i_err          = 1'b0;
    d_ack          = 1'b0;
    d_rdata        = '0;
    d_err          = 1'b0;

    half    = (state_reg == HI_REQ || state_reg == HI_WAIT) ? HALF_HI : HALF_LO;
    in_xfer = (state_reg == LO_REQ) || (state_reg == LO_WAIT) ||
              (state_reg == HI_REQ) || (state_reg == HI_WAIT);

    case (state_reg)
      IDLE: begin
        // Requests are only sampled here; mem_ack is ignored.
        if (i_req || d_req) begin
          grant_next  = rr_pick;
          addr_next   = (rr_pick == GNT_DATA) ? d_addr : i_addr;
          we_next     = (rr_pick == GNT_DATA) && d_we;
          wdata_next  = ((rr_pick == GNT_DATA) && d_we) ? d_wdata : 32'h0;
          result_next = '0;
          err_next    = 1'b0;
          state_next  = LO_REQ;
        end
      end
      LO_REQ: begin
        mem_read   = !we_reg;
        mem_write  = we_reg;
        cnt_next   = '0;
        state_next = LO_WAIT;
      end
      LO_WAIT: begin
        if (mem_ack) begin
          result_next[15:0] = mem_read_data[15:0];
          state_next        = HI_REQ;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      HI_REQ: begin
        mem_read   = !we_reg;
        mem_write  = we_reg;
        cnt_next   = '0;
        state_next = HI_WAIT;
      end
      HI_WAIT: begin
        if (mem_ack) begin
          result_next[31:16] = mem_read_data[15:0];
          state_next         = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        // Read data is only returned for a read that completed both halves.
        if (grant_reg == GNT_DATA) begin
          d_ack   = 1'b1;
          d_err   = err_reg;
          d_rdata = (!we_reg && !err_reg) ? result_reg : 32'h0;
        end else begin
          i_ack   = 1'b1;
          i_err   = err_reg;
          i_rdata = !err_reg ? result_reg : 32'h0;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Address and write data are held from the strobe through the wait.
    if (in_xfer) begin
      mem_addr[WADDR_W:0] = {addr_reg, half};
      mem_write_data      = {16'h0, (half == HALF_HI) ? wdata_reg[31:16] : wdata_reg[15:0]};
    end
  end

  assign busy  = (state_reg != IDLE);
  assign grant = grant_reg;

endmodule
